// File: rtl/tag_uniq_pkg.sv
// Shared defaults, table types and helpers for the tag-uniqueness tracker.
package tag_uniq_pkg;

  localparam int unsigned DEF_NCH   = 8;
  localparam int unsigned DEF_TAG_W = 16;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_CNT_W = 8;

  // Widest channel vector the popcount helper accepts.
  localparam int unsigned POP_W = 64;

  typedef logic [DEF_TAG_W-1:0] tag_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } entry_t;

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tag_uniq_cam.sv
// Parallel match of one key against every valid entry of the tag table.
module tag_uniq_cam #(
  parameter int unsigned TAG_W = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags_i,
  input  logic [TAG_W-1:0]            key_i,
  output logic                        hit_o,
  output logic [DEPTH-1:0]            match_o
);

  always_comb begin
    match_o = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      match_o[e] = valid_i[e] && (tags_i[e] == key_i);
    end
  end

  assign hit_o = |match_o;

endmodule

// File: rtl/tag_uniq_tracker.sv
// Outstanding-tag table for NCH allocate channels and one release port;
// duplicates are flagged and dropped, releases of unknown tags are flagged.
module tag_uniq_tracker
  import tag_uniq_pkg::*;
#(
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NCH-1:0]                 alloc_vld,
  input  logic [NCH-1:0][TAG_W-1:0]      alloc_tag,
  output logic                           alloc_rdy,
  input  logic                           rel_vld,
  input  logic [TAG_W-1:0]               rel_tag,
  input  logic                           err_clr,
  output logic [NCH-1:0]                 collide,
  output logic                           rel_miss,
  output logic                           err_sticky,
  output logic [CNT_W-1:0]               err_cnt,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic [NCH-1:0]              collide_q, collide_d;
  logic                        rel_miss_q, rel_miss_d;
  logic                        sticky_q, sticky_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic                        rel_hit_raw;
  logic                        rel_hit;
  logic [DEPTH-1:0]            rel_match;
  logic [DEPTH-1:0]            view_vld;
  logic [NCH-1:0]              alloc_hit;
  logic [DEPTH-1:0]            alloc_match_unused [NCH];
  logic [NCH-1:0]              intra_dup;
  logic [NCH-1:0]              accept;
  logic [DEPTH-1:0]            free_slots;
  int unsigned                 n_acc;
  int unsigned                 err_inc;
  int unsigned                 cnt_sum;

  assign alloc_rdy = (DEPTH - 32'(occ_q)) >= NCH;

  tag_uniq_cam #(
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) u_rel_cam (
    .valid_i (vld_q),
    .tags_i  (tag_q),
    .key_i   (rel_tag),
    .hit_o   (rel_hit_raw),
    .match_o (rel_match)
  );

  assign rel_hit  = rel_vld & rel_hit_raw;
  // Allocations compare against the table with this cycle's release removed.
  assign view_vld = vld_q & ~(rel_match & {DEPTH{rel_vld}});

  for (genvar ch = 0; ch < NCH; ch++) begin : g_alloc_cam
    tag_uniq_cam #(
      .TAG_W (TAG_W),
      .DEPTH (DEPTH)
    ) u_alloc_cam (
      .valid_i (view_vld),
      .tags_i  (tag_q),
      .key_i   (alloc_tag[ch]),
      .hit_o   (alloc_hit[ch]),
      .match_o (alloc_match_unused[ch])
    );
  end

  // Lower channel index wins any same-cycle tie.
  always_comb begin
    intra_dup = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      for (int unsigned j = 0; j < NCH; j++) begin
        if (j < i && alloc_vld[j] && (alloc_tag[j] == alloc_tag[i])) begin
          intra_dup[i] = 1'b1;
        end
      end
    end
  end

  assign accept    = alloc_vld & ~(alloc_hit | intra_dup) & {NCH{alloc_rdy}};
  assign collide_d = alloc_vld &  (alloc_hit | intra_dup) & {NCH{alloc_rdy}};
  assign rel_miss_d = rel_vld & ~rel_hit_raw;

  // Each accepted channel claims the lowest free slot left by earlier channels.
  always_comb begin
    logic placed;
    vld_d      = view_vld;
    tag_d      = tag_q;
    free_slots = ~view_vld;
    n_acc      = 0;
    placed     = 1'b0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      placed = 1'b0;
      if (accept[ch]) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
          if (!placed && free_slots[e]) begin
            vld_d[e]      = 1'b1;
            tag_d[e]      = alloc_tag[ch];
            free_slots[e] = 1'b0;
            placed        = 1'b1;
          end
        end
        n_acc++;
      end
    end
  end

  assign occ_d = occ_q - OCC_W'(rel_hit) + OCC_W'(n_acc);

  always_comb begin
    sticky_d = (|collide_d) | rel_miss_d | (sticky_q & ~err_clr);
    err_inc  = popcount(POP_W'(collide_d)) + {31'b0, rel_miss_d};
    cnt_sum  = (err_clr ? 0 : 32'(cnt_q)) + err_inc;
    cnt_d    = (cnt_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(cnt_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      tag_q      <= '0;
      occ_q      <= '0;
      collide_q  <= '0;
      rel_miss_q <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      occ_q      <= occ_d;
      collide_q  <= collide_d;
      rel_miss_q <= rel_miss_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign collide    = collide_q;
  assign rel_miss   = rel_miss_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_tag_uniq_tracker.sv
// Directed bench for tag_uniq_tracker at NCH=8, TAG_W=16, DEPTH=16, CNT_W=8.
module tb_tag_uniq_tracker;

  logic              clk;
  logic              rst;
  logic [7:0]        alloc_vld;
  logic [7:0][15:0]  alloc_tag;
  logic              alloc_rdy;
  logic              rel_vld;
  logic [15:0]       rel_tag;
  logic              err_clr;
  logic [7:0]        collide;
  logic              rel_miss;
  logic              err_sticky;
  logic [7:0]        err_cnt;
  logic [4:0]        occupancy;

  int checks;
  int failures;

  tag_uniq_tracker #(
    .NCH   (8),
    .TAG_W (16),
    .DEPTH (16),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_vld  (alloc_vld),
    .alloc_tag  (alloc_tag),
    .alloc_rdy  (alloc_rdy),
    .rel_vld    (rel_vld),
    .rel_tag    (rel_tag),
    .err_clr    (err_clr),
    .collide    (collide),
    .rel_miss   (rel_miss),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    alloc_vld = '0;
    alloc_tag = '0;
    rel_vld   = 1'b0;
    rel_tag   = '0;
    err_clr   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (collide !== 8'h00) begin failures++; $display("FAIL reset_collide got=%h exp=00", collide); end
    checks++; if (rel_miss !== 1'b0 || err_sticky !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", rel_miss, err_sticky); end
    checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%h exp=00", err_cnt); end
    checks++; if (alloc_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", alloc_rdy); end
    rst = 1'b0;
  endtask

  task automatic test_single_alloc();
    idle();
    alloc_vld    = 8'h01;
    alloc_tag[0] = 16'h00A5;
    step();
    checks++; if (occupancy !== 5'd1) begin failures++; $display("FAIL single_occ got=%0d exp=1", occupancy); end
    checks++; if (collide !== 8'h00) begin failures++; $display("FAIL single_collide got=%h exp=00", collide); end
    checks++; if (err_cnt !== 8'h00 || err_sticky !== 1'b0) begin failures++; $display("FAIL single_err got=%h/%b exp=00/0", err_cnt, err_sticky); end
  endtask

  task automatic test_table_dup();
    idle();
    alloc_vld    = 8'h08;
    alloc_tag[3] = 16'h00A5;
    step();
    checks++; if (collide !== 8'h08) begin failures++; $display("FAIL tbl_dup_collide got=%h exp=08", collide); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL tbl_dup_sticky got=%b exp=1", err_sticky); end
    checks++; if (err_cnt !== 8'h01) begin failures++; $display("FAIL tbl_dup_cnt got=%h exp=01", err_cnt); end
    checks++; if (occupancy !== 5'd1) begin failures++; $display("FAIL tbl_dup_occ got=%0d exp=1", occupancy); end
    idle();
    step();
    checks++; if (collide !== 8'h00) begin failures++; $display("FAIL tbl_dup_pulse got=%h exp=00", collide); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL tbl_dup_hold got=%b exp=1", err_sticky); end
  endtask

  task automatic test_intra_dup();
    idle();
    alloc_vld    = 8'h21;
    alloc_tag[0] = 16'h1234;
    alloc_tag[5] = 16'h1234;
    step();
    checks++; if (collide !== 8'h20) begin failures++; $display("FAIL intra_collide got=%h exp=20", collide); end
    checks++; if (occupancy !== 5'd2) begin failures++; $display("FAIL intra_occ got=%0d exp=2", occupancy); end
    checks++; if (err_cnt !== 8'h02) begin failures++; $display("FAIL intra_cnt got=%h exp=02", err_cnt); end
    idle();
    alloc_vld    = 8'h04;
    alloc_tag[2] = 16'h1234;
    step();
    checks++; if (collide !== 8'h04) begin failures++; $display("FAIL intra_winner got=%h exp=04", collide); end
    checks++; if (err_cnt !== 8'h03) begin failures++; $display("FAIL intra_cnt2 got=%h exp=03", err_cnt); end
  endtask

  task automatic test_release_realloc();
    idle();
    rel_vld      = 1'b1;
    rel_tag      = 16'h00A5;
    alloc_vld    = 8'h02;
    alloc_tag[1] = 16'h00A5;
    step();
    checks++; if (collide !== 8'h00 || rel_miss !== 1'b0) begin failures++; $display("FAIL relalloc_flags got=%h/%b exp=00/0", collide, rel_miss); end
    checks++; if (occupancy !== 5'd2) begin failures++; $display("FAIL relalloc_occ got=%0d exp=2", occupancy); end
    idle();
    rel_vld = 1'b1;
    rel_tag = 16'hBEEF;
    step();
    checks++; if (rel_miss !== 1'b1) begin failures++; $display("FAIL relmiss got=%b exp=1", rel_miss); end
    checks++; if (err_cnt !== 8'h04) begin failures++; $display("FAIL relmiss_cnt got=%h exp=04", err_cnt); end
    checks++; if (occupancy !== 5'd2) begin failures++; $display("FAIL relmiss_occ got=%0d exp=2", occupancy); end
    idle();
    step();
    checks++; if (rel_miss !== 1'b0) begin failures++; $display("FAIL relmiss_pulse got=%b exp=0", rel_miss); end
  endtask

  task automatic test_full();
    idle();
    alloc_vld = 8'h7F;
    for (int i = 0; i < 7; i++) alloc_tag[i] = 16'h0100 + 16'(i);
    step();
    checks++; if (occupancy !== 5'd9) begin failures++; $display("FAIL full_occ got=%0d exp=9", occupancy); end
    checks++; if (alloc_rdy !== 1'b0) begin failures++; $display("FAIL full_rdy got=%b exp=0", alloc_rdy); end
    idle();
    alloc_vld = 8'hFF;
    for (int i = 0; i < 8; i++) alloc_tag[i] = 16'h0200 + 16'(i);
    alloc_tag[0] = 16'h00A5;
    step();
    checks++; if (occupancy !== 5'd9) begin failures++; $display("FAIL full_hold_occ got=%0d exp=9", occupancy); end
    checks++; if (collide !== 8'h00 || err_cnt !== 8'h04) begin failures++; $display("FAIL full_hold_err got=%h/%h exp=00/04", collide, err_cnt); end
    idle();
    rel_vld = 1'b1;
    rel_tag = 16'h0100;
    step();
    checks++; if (occupancy !== 5'd8) begin failures++; $display("FAIL full_rel_occ got=%0d exp=8", occupancy); end
    checks++; if (alloc_rdy !== 1'b1 || rel_miss !== 1'b0) begin failures++; $display("FAIL full_rel_rdy got=%b/%b exp=1/0", alloc_rdy, rel_miss); end
  endtask

  task automatic test_saturate();
    idle();
    alloc_vld = 8'hFF;
    for (int i = 0; i < 8; i++) alloc_tag[i] = 16'h00A5;
    rel_vld = 1'b1;
    rel_tag = 16'hBEEF;
    step();
    checks++; if (collide !== 8'hFF || err_cnt !== 8'h0D) begin failures++; $display("FAIL sat_first got=%h/%h exp=FF/0D", collide, err_cnt); end
    repeat (28) step();
    checks++; if (err_cnt !== 8'hFF) begin failures++; $display("FAIL sat_cnt got=%h exp=FF", err_cnt); end
    step();
    checks++; if (err_cnt !== 8'hFF) begin failures++; $display("FAIL sat_hold got=%h exp=FF", err_cnt); end
    checks++; if (occupancy !== 5'd8) begin failures++; $display("FAIL sat_occ got=%0d exp=8", occupancy); end
    idle();
    err_clr      = 1'b1;
    alloc_vld    = 8'h01;
    alloc_tag[0] = 16'h00A5;
    step();
    checks++; if (err_cnt !== 8'h01 || err_sticky !== 1'b1) begin failures++; $display("FAIL clr_collide got=%h/%b exp=01/1", err_cnt, err_sticky); end
    idle();
    err_clr = 1'b1;
    step();
    checks++; if (err_cnt !== 8'h00 || err_sticky !== 1'b0) begin failures++; $display("FAIL clr_only got=%h/%b exp=00/0", err_cnt, err_sticky); end
  endtask

  task automatic test_rst_mid();
    idle();
    alloc_vld = 8'hFF;
    for (int i = 0; i < 8; i++) alloc_tag[i] = 16'h00A5;
    rel_vld = 1'b1;
    rel_tag = 16'hBEEF;
    step();
    checks++; if (collide !== 8'hFF || err_cnt !== 8'h09) begin failures++; $display("FAIL burst got=%h/%h exp=FF/09", collide, err_cnt); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (collide !== 8'h00 || rel_miss !== 1'b0) begin failures++; $display("FAIL rstmid_pulses got=%h/%b exp=00/0", collide, rel_miss); end
    checks++; if (err_cnt !== 8'h00 || err_sticky !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%h/%b exp=00/0", err_cnt, err_sticky); end
    checks++; if (occupancy !== 5'd0 || alloc_rdy !== 1'b1) begin failures++; $display("FAIL rstmid_occ got=%0d/%b exp=0/1", occupancy, alloc_rdy); end
    idle();
    step();
    rst = 1'b0;
    step();
    checks++; if (collide !== 8'h00 || occupancy !== 5'd0) begin failures++; $display("FAIL post_rst got=%h/%0d exp=00/0", collide, occupancy); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_alloc();
    test_table_dup();
    test_intra_dup();
    test_release_realloc();
    test_full();
    test_saturate();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
